// File: rtl/id_2r_stage.sv
// id_2r_stage: decode stage for the counter / CPUCFG instruction group.
// Each lane is decoded combinationally at the input. The decoded bundle is
// held in a two-entry skid buffer: a main register that drives the outputs
// and a skid register. in_ready is registered and means "skid register is
// empty", so it never depends combinationally on out_ready.
module id_2r_stage #(
   parameter int DECODE_WIDTH = 2,
   parameter int EXC_W        = 7
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DECODE_WIDTH-1:0]       in_lane_mask,
   input  logic [32*DECODE_WIDTH-1:0]    in_pc,
   input  logic [32*DECODE_WIDTH-1:0]    in_inst,
   input  logic [EXC_W*DECODE_WIDTH-1:0] in_exc_cause,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DECODE_WIDTH-1:0]       out_lane_mask,
   output logic [32*DECODE_WIDTH-1:0]    out_pc,
   output logic [32*DECODE_WIDTH-1:0]    out_inst,
   output logic [DECODE_WIDTH-1:0]       out_inst_valid,
   output logic [DECODE_WIDTH-1:0]       out_reg_write_en,
   output logic [DECODE_WIDTH-1:0]       out_reg1_read_en,
   output logic [DECODE_WIDTH-1:0]       out_csr_read_en,
   output logic [DECODE_WIDTH-1:0]       out_is_cnt,
   output logic [DECODE_WIDTH-1:0]       out_is_exception,
   output logic [5*DECODE_WIDTH-1:0]     out_reg_write_addr,
   output logic [5*DECODE_WIDTH-1:0]     out_reg1_read_addr,
   output logic [8*DECODE_WIDTH-1:0]     out_aluop,
   output logic [3*DECODE_WIDTH-1:0]     out_alusel,
   output logic [EXC_W*DECODE_WIDTH-1:0] out_exception_cause
);

   // ALU operation / selector / exception codes used by this stage
   localparam logic [7:0]       ALU_NOP       = 8'h00;
   localparam logic [7:0]       ALU_RDCNTID   = 8'h60;
   localparam logic [7:0]       ALU_RDCNTVL   = 8'h61;
   localparam logic [7:0]       ALU_RDCNTVH   = 8'h62;
   localparam logic [7:0]       ALU_CPUCFG    = 8'h63;
   localparam logic [2:0]       ALU_SEL_NOP   = 3'b000;
   localparam logic [2:0]       ALU_SEL_CSR   = 3'b110;
   localparam logic [EXC_W-1:0] EXCEPTION_INE = EXC_W'(7'h0D);

   localparam logic [21:0] OP_CPUCFG = 22'h00001B;
   localparam logic [21:0] OP_RDCNT_L = 22'h000018;
   localparam logic [21:0] OP_RDCNT_H = 22'h000019;

   // Per-lane record layout, LSB first:
   //   cause, alusel, aluop, rd1_addr, wr_addr, is_exc, is_cnt, csr_rd_en,
   //   reg1_rd_en, wr_en, inst_valid, inst, pc, lane_present
   localparam int LW = EXC_W + 92;
   localparam int BW = DECODE_WIDTH * LW;

   // Decode one lane into its packed record; absent lanes are all zero.
   function automatic logic [LW-1:0] decode_lane(
      input logic             present,
      input logic [31:0]      pc,
      input logic [31:0]      inst,
      input logic [EXC_W-1:0] exc
   );
      logic [21:0]      opcode;
      logic [4:0]       rj;
      logic [4:0]       rd;
      logic             iv, we, r1e, csre, cnt, is_exc;
      logic [4:0]       wa, ra;
      logic [7:0]       aluop;
      logic [2:0]       alusel;
      logic [EXC_W-1:0] cause;
      opcode = inst[31:10];
      rj     = inst[9:5];
      rd     = inst[4:0];
      iv     = 1'b0;
      we     = 1'b0;
      r1e    = 1'b0;
      csre   = 1'b0;
      cnt    = 1'b0;
      is_exc = 1'b0;
      wa     = 5'd0;
      ra     = 5'd0;
      aluop  = ALU_NOP;
      alusel = ALU_SEL_NOP;
      cause  = '0;
      if (opcode == OP_CPUCFG) begin
         iv     = 1'b1;
         we     = 1'b1;
         wa     = rd;
         r1e    = 1'b1;
         ra     = rj;
         csre   = 1'b1;
         aluop  = ALU_CPUCFG;
         alusel = ALU_SEL_CSR;
      end else if (opcode == OP_RDCNT_L && rd == 5'd0 && rj != 5'd0) begin
         // RDCNTID.W writes its result to rj, not rd
         iv     = 1'b1;
         we     = 1'b1;
         wa     = rj;
         cnt    = 1'b1;
         csre   = 1'b1;
         aluop  = ALU_RDCNTID;
         alusel = ALU_SEL_CSR;
      end else if (opcode == OP_RDCNT_L && rj == 5'd0) begin
         // rd == 0 is legal here and simply suppresses the write
         iv     = 1'b1;
         we     = (rd != 5'd0);
         wa     = rd;
         cnt    = 1'b1;
         aluop  = ALU_RDCNTVL;
         alusel = ALU_SEL_CSR;
      end else if (opcode == OP_RDCNT_H && rj == 5'd0) begin
         iv     = 1'b1;
         we     = (rd != 5'd0);
         wa     = rd;
         cnt    = 1'b1;
         aluop  = ALU_RDCNTVH;
         alusel = ALU_SEL_CSR;
      end else begin
         is_exc = 1'b1;
         cause  = EXCEPTION_INE;
      end
      // An upstream exception outranks INE and kills all register/CSR access
      if (exc != '0) begin
         is_exc = 1'b1;
         cause  = exc;
         we     = 1'b0;
         r1e    = 1'b0;
         csre   = 1'b0;
      end
      if (!present) begin
         return '0;
      end
      return {1'b1, pc, inst, iv, we, r1e, csre, cnt, is_exc,
              wa, ra, aluop, alusel, cause};
   endfunction

   logic [BW-1:0] in_bundle;
   logic [BW-1:0] main_q;
   logic [BW-1:0] skid_q;
   logic          main_vld;
   logic          skid_vld;
   logic          in_ready_q;
   logic          in_fire;
   logic          out_fire;
   logic          main_vld_n;
   logic          skid_vld_n;
   logic          ld_main_in;
   logic          ld_main_skid;
   logic          ld_skid;

   // Decode every lane of the incoming bundle
   always_comb begin
      in_bundle = '0;
      for (int l = 0; l < DECODE_WIDTH; l++) begin
         in_bundle[l*LW +: LW] = decode_lane(in_lane_mask[l],
                                             in_pc[l*32 +: 32],
                                             in_inst[l*32 +: 32],
                                             in_exc_cause[l*EXC_W +: EXC_W]);
      end
   end

   // Bundles with no lane present are accepted but never stored; flush drops input
   assign in_fire  = in_valid & in_ready_q & ~flush & (|in_lane_mask);
   assign out_fire = main_vld & out_ready;

   // Next-state and load selection for the two buffer entries
   always_comb begin
      main_vld_n   = main_vld;
      skid_vld_n   = skid_vld;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush) begin
         main_vld_n = 1'b0;
         skid_vld_n = 1'b0;
      end else if (!main_vld) begin
         if (in_fire) begin
            main_vld_n = 1'b1;
            ld_main_in = 1'b1;
         end
      end else if (out_fire) begin
         if (skid_vld) begin
            // in_ready is low while skid is full, so no new input competes
            ld_main_skid = 1'b1;
            skid_vld_n   = 1'b0;
         end else if (in_fire) begin
            ld_main_in = 1'b1;
         end else begin
            main_vld_n = 1'b0;
         end
      end else if (in_fire) begin
         ld_skid    = 1'b1;
         skid_vld_n = 1'b1;
      end
   end

   // Control registers; in_ready stays low until the first edge after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld   <= 1'b0;
         skid_vld   <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         main_vld   <= main_vld_n;
         skid_vld   <= skid_vld_n;
         in_ready_q <= ~skid_vld_n;
      end
   end

   // Payload registers; main holds steady unless it drains or is reloaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (ld_main_in) begin
            main_q <= in_bundle;
         end else if (ld_main_skid) begin
            main_q <= skid_q;
         end
         if (ld_skid) begin
            skid_q <= in_bundle;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_vld;

   for (genvar l = 0; l < DECODE_WIDTH; l++) begin : g_lane
      localparam int B = l * LW;
      assign out_exception_cause[l*EXC_W +: EXC_W] = main_q[B +: EXC_W];
      assign out_alusel[l*3 +: 3]                  = main_q[B+EXC_W +: 3];
      assign out_aluop[l*8 +: 8]                   = main_q[B+EXC_W+3 +: 8];
      assign out_reg1_read_addr[l*5 +: 5]          = main_q[B+EXC_W+11 +: 5];
      assign out_reg_write_addr[l*5 +: 5]          = main_q[B+EXC_W+16 +: 5];
      assign out_is_exception[l]                   = main_q[B+EXC_W+21];
      assign out_is_cnt[l]                         = main_q[B+EXC_W+22];
      assign out_csr_read_en[l]                    = main_q[B+EXC_W+23];
      assign out_reg1_read_en[l]                   = main_q[B+EXC_W+24];
      assign out_reg_write_en[l]                   = main_q[B+EXC_W+25];
      assign out_inst_valid[l]                     = main_q[B+EXC_W+26];
      assign out_inst[l*32 +: 32]                  = main_q[B+EXC_W+27 +: 32];
      assign out_pc[l*32 +: 32]                    = main_q[B+EXC_W+59 +: 32];
      assign out_lane_mask[l]                      = main_q[B+EXC_W+91];
   end

endmodule

// File: tb/tb_id_2r_stage.sv
// Testbench for id_2r_stage: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the decode stage.
module tb_id_2r_stage;

   localparam int DW = 2;
   localparam int EW = 7;

   localparam logic [7:0]    A_NOP     = 8'h00;
   localparam logic [7:0]    A_CNTID   = 8'h60;
   localparam logic [7:0]    A_CNTVL   = 8'h61;
   localparam logic [7:0]    A_CNTVH   = 8'h62;
   localparam logic [7:0]    A_CPUCFG  = 8'h63;
   localparam logic [2:0]    S_NOP     = 3'b000;
   localparam logic [2:0]    S_CSR     = 3'b110;
   localparam logic [EW-1:0] E_INE     = 7'h0D;

   typedef struct packed {
      logic          mask;
      logic [31:0]   pc;
      logic [31:0]   inst;
      logic          iv;
      logic          we;
      logic          r1e;
      logic          csre;
      logic          cnt;
      logic          exc;
      logic [4:0]    wa;
      logic [4:0]    ra;
      logic [7:0]    aluop;
      logic [2:0]    alusel;
      logic [EW-1:0] cause;
   } lane_t;

   typedef enum int {K_CPUCFG, K_CNTID, K_CNTVL, K_CNTVH, K_ILLEGAL} kind_e;

   logic                clk;
   logic                rst_n;
   logic                flush;
   logic                in_valid;
   logic                in_ready;
   logic [DW-1:0]       in_lane_mask;
   logic [32*DW-1:0]    in_pc;
   logic [32*DW-1:0]    in_inst;
   logic [EW*DW-1:0]    in_exc_cause;
   logic                out_valid;
   logic                out_ready;
   logic [DW-1:0]       out_lane_mask;
   logic [32*DW-1:0]    out_pc;
   logic [32*DW-1:0]    out_inst;
   logic [DW-1:0]       out_inst_valid;
   logic [DW-1:0]       out_reg_write_en;
   logic [DW-1:0]       out_reg1_read_en;
   logic [DW-1:0]       out_csr_read_en;
   logic [DW-1:0]       out_is_cnt;
   logic [DW-1:0]       out_is_exception;
   logic [5*DW-1:0]     out_reg_write_addr;
   logic [5*DW-1:0]     out_reg1_read_addr;
   logic [8*DW-1:0]     out_aluop;
   logic [3*DW-1:0]     out_alusel;
   logic [EW*DW-1:0]    out_exception_cause;

   id_2r_stage #(.DECODE_WIDTH(DW), .EXC_W(EW)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .flush               (flush),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_lane_mask        (in_lane_mask),
      .in_pc               (in_pc),
      .in_inst             (in_inst),
      .in_exc_cause        (in_exc_cause),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_lane_mask       (out_lane_mask),
      .out_pc              (out_pc),
      .out_inst            (out_inst),
      .out_inst_valid      (out_inst_valid),
      .out_reg_write_en    (out_reg_write_en),
      .out_reg1_read_en    (out_reg1_read_en),
      .out_csr_read_en     (out_csr_read_en),
      .out_is_cnt          (out_is_cnt),
      .out_is_exception    (out_is_exception),
      .out_reg_write_addr  (out_reg_write_addr),
      .out_reg1_read_addr  (out_reg1_read_addr),
      .out_aluop           (out_aluop),
      .out_alusel          (out_alusel),
      .out_exception_cause (out_exception_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_vec;
   int    n_err;
   lane_t q_l0[$];
   lane_t q_l1[$];
   bit    mdl_rdy;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Reference decode: classify the word, then fill fields per instruction kind
   function automatic lane_t mdl(input logic m, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic [EW-1:0] exc);
      lane_t e;
      kind_e k;
      logic [21:0] op;
      logic [4:0]  rj;
      logic [4:0]  rd;
      e = '0;
      if (!m) return e;
      op = inst[31:10];
      rj = inst[9:5];
      rd = inst[4:0];
      if (op == 22'h1B)                 k = K_CPUCFG;
      else if (op == 22'h18 && rj == 0) k = K_CNTVL;
      else if (op == 22'h18 && rd == 0) k = K_CNTID;
      else if (op == 22'h19 && rj == 0) k = K_CNTVH;
      else                              k = K_ILLEGAL;
      e.mask = 1'b1;
      e.pc   = pc;
      e.inst = inst;
      e.aluop  = A_NOP;
      e.alusel = S_NOP;
      case (k)
         K_CPUCFG: begin
            e.iv = 1; e.we = 1; e.wa = rd; e.r1e = 1; e.ra = rj; e.csre = 1;
            e.aluop = A_CPUCFG; e.alusel = S_CSR;
         end
         K_CNTID: begin
            e.iv = 1; e.we = 1; e.wa = rj; e.cnt = 1; e.csre = 1;
            e.aluop = A_CNTID; e.alusel = S_CSR;
         end
         K_CNTVL: begin
            e.iv = 1; e.we = (rd != 0); e.wa = rd; e.cnt = 1;
            e.aluop = A_CNTVL; e.alusel = S_CSR;
         end
         K_CNTVH: begin
            e.iv = 1; e.we = (rd != 0); e.wa = rd; e.cnt = 1;
            e.aluop = A_CNTVH; e.alusel = S_CSR;
         end
         default: begin
            e.exc = 1; e.cause = E_INE;
         end
      endcase
      if (exc != 0) begin
         e.exc = 1; e.cause = exc; e.we = 0; e.r1e = 0; e.csre = 0;
      end
      return e;
   endfunction

   function automatic lane_t act_lane(input int i);
      lane_t a;
      a.mask   = out_lane_mask[i];
      a.pc     = out_pc[i*32 +: 32];
      a.inst   = out_inst[i*32 +: 32];
      a.iv     = out_inst_valid[i];
      a.we     = out_reg_write_en[i];
      a.r1e    = out_reg1_read_en[i];
      a.csre   = out_csr_read_en[i];
      a.cnt    = out_is_cnt[i];
      a.exc    = out_is_exception[i];
      a.wa     = out_reg_write_addr[i*5 +: 5];
      a.ra     = out_reg1_read_addr[i*5 +: 5];
      a.aluop  = out_aluop[i*8 +: 8];
      a.alusel = out_alusel[i*3 +: 3];
      a.cause  = out_exception_cause[i*EW +: EW];
      return a;
   endfunction

   task automatic check_state();
      chk("out_valid", 128'(out_valid), 128'(q_l0.size() > 0));
      chk("in_ready", 128'(in_ready), 128'(mdl_rdy && q_l0.size() < 2));
      if (q_l0.size() > 0) begin
         chk("lane0", 128'(act_lane(0)), 128'(q_l0[0]));
         chk("lane1", 128'(act_lane(1)), 128'(q_l1[0]));
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, check after
   task automatic step(input bit iv, input logic [1:0] m,
                       input logic [31:0] p0, input logic [31:0] i0,
                       input logic [31:0] p1, input logic [31:0] i1,
                       input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                       input bit ordy, input bit fl);
      bit rdy_pre;
      in_valid     = iv;
      in_lane_mask = m;
      in_pc        = {p1, p0};
      in_inst      = {i1, i0};
      in_exc_cause = {e1, e0};
      out_ready    = ordy;
      flush        = fl;
      rdy_pre = mdl_rdy && (q_l0.size() < 2);
      @(posedge clk);
      if (fl) begin
         q_l0.delete();
         q_l1.delete();
      end else begin
         if (q_l0.size() > 0 && ordy) begin
            void'(q_l0.pop_front());
            void'(q_l1.pop_front());
         end
         if (iv && rdy_pre && m != 0) begin
            q_l0.push_back(mdl(m[0], p0, i0, e0));
            q_l1.push_back(mdl(m[1], p1, i1, e1));
         end
      end
      mdl_rdy = 1'b1;
      @(negedge clk);
      check_state();
   endtask

   task automatic idle(input bit ordy);
      step(0, 2'b00, 0, 0, 0, 0, 0, 0, ordy, 0);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [4:0] rj;
      logic [4:0] rd;
      rj = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      rd = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      case ($urandom_range(0, 5))
         0:       return {22'h1B, rj, rd};
         1:       return {22'h18, rj, 5'd0};
         2:       return {22'h18, 5'd0, rd};
         3:       return {22'h19, rj, rd};
         4:       return {22'h18, rj, rd};
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [EW-1:0] rand_exc();
      return ($urandom_range(0, 6) == 0) ? EW'($urandom) : '0;
   endfunction

   localparam logic [31:0] I_CPUCFG = 32'h00006C85;

   initial begin
      n_vec = 0;
      n_err = 0;
      mdl_rdy = 1'b0;
      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      in_lane_mask = '0;
      in_pc = '0;
      in_inst = '0;
      in_exc_cause = '0;
      out_ready = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_out_pc", 128'(out_pc), 128'(0));
      rst_n = 1'b1;
      idle(1);
      chk("ready_after_rst", 128'(in_ready), 128'(1));

      // CPUCFG r5, r4
      step(1, 2'b01, 32'h1000, I_CPUCFG, 0, 0, 0, 0, 1, 0);
      chk("cpucfg_valid", 128'(out_valid), 128'(1));
      chk("cpucfg_we", 128'(out_reg_write_en[0]), 128'(1));
      chk("cpucfg_wa", 128'(out_reg_write_addr[4:0]), 128'(5));
      chk("cpucfg_ra", 128'(out_reg1_read_addr[4:0]), 128'(4));
      chk("cpucfg_aluop", 128'(out_aluop[7:0]), 128'(8'h63));

      // RDCNTVL.W r6 / RDCNTID.W r7
      step(1, 2'b11, 32'h2000, 32'h00006006, 32'h2004, 32'h000060E0, 0, 0, 1, 0);
      chk("cntvl_wa", 128'(out_reg_write_addr[4:0]), 128'(6));
      chk("cntvl_cnt", 128'(out_is_cnt[0]), 128'(1));
      chk("cntid_wa", 128'(out_reg_write_addr[9:5]), 128'(7));
      chk("cntid_aluop", 128'(out_aluop[15:8]), 128'(8'h60));

      // illegal word, then same word carrying an upstream cause
      step(1, 2'b01, 32'h3000, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0);
      chk("ine_exc", 128'(out_is_exception[0]), 128'(1));
      chk("ine_cause", 128'(out_exception_cause[6:0]), 128'(7'h0D));
      step(1, 2'b01, 32'h3004, 32'hFFFFFFFF, 0, 0, 7'h08, 0, 1, 0);
      chk("upstream_cause", 128'(out_exception_cause[6:0]), 128'(7'h08));

      // an empty lane mask is swallowed
      step(1, 2'b00, 32'h3008, I_CPUCFG, 0, 0, 0, 0, 1, 0);
      chk("empty_mask", 128'(out_valid), 128'(0));

      // back-pressure: 3 bundles offered, 2 accepted, drained in order
      step(1, 2'b01, 32'h100, I_CPUCFG, 0, 0, 0, 0, 0, 0);
      step(1, 2'b01, 32'h200, I_CPUCFG, 0, 0, 0, 0, 0, 0);
      chk("bp_full_ready", 128'(in_ready), 128'(0));
      step(1, 2'b01, 32'h300, I_CPUCFG, 0, 0, 0, 0, 0, 0);
      chk("bp_hold_pc", 128'(out_pc[31:0]), 128'(32'h100));
      idle(1);
      chk("bp_second_pc", 128'(out_pc[31:0]), 128'(32'h200));
      idle(1);
      chk("bp_no_third", 128'(out_valid), 128'(0));

      // flush with both entries full and an input offered
      step(1, 2'b01, 32'h400, I_CPUCFG, 0, 0, 0, 0, 0, 0);
      step(1, 2'b01, 32'h500, I_CPUCFG, 0, 0, 0, 0, 0, 0);
      step(1, 2'b01, 32'h600, I_CPUCFG, 0, 0, 0, 0, 1, 1);
      chk("flush_valid", 128'(out_valid), 128'(0));
      chk("flush_ready", 128'(in_ready), 128'(1));
      idle(1);
      chk("flush_nothing", 128'(out_valid), 128'(0));

      // asynchronous reset with main full
      step(1, 2'b01, 32'h700, I_CPUCFG, 0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 128'(out_valid), 128'(0));
      chk("async_rst_ready", 128'(in_ready), 128'(0));
      chk("async_rst_pc", 128'(out_pc), 128'(0));
      q_l0.delete();
      q_l1.delete();
      mdl_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      step(1, 2'b01, 32'h800, I_CPUCFG, 0, 0, 0, 0, 1, 0);
      chk("post_rst_pc", 128'(out_pc[31:0]), 128'(32'h800));
      chk("post_rst_wa", 128'(out_reg_write_addr[4:0]), 128'(5));

      // random traffic
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
              $urandom, rand_inst(), $urandom, rand_inst(),
              rand_exc(), rand_exc(),
              $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
